// File: rtl/secded_error_corrector.sv
// SECDED correction stage: flips bits where both syndrome checks fail, unless a double error is flagged.
// Optional error statistics counters are enabled by defining SECDED_ERR_STATS_EN.
module secded_error_corrector #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] e1,
  input  logic [WIDTH-1:0] e2,
  input  logic             DEDb,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] di,
  output logic             corrected,
  output logic             uncorrectable
`ifdef SECDED_ERR_STATS_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] ded_cnt
`endif
);

  logic [WIDTH-1:0] di_c;
  logic [WIDTH-1:0] data_c;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_out_q,  data_out_d;
  logic [WIDTH-1:0] di_q,        di_d;
  logic             corrected_q, corrected_d;
  logic             uncorr_q,    uncorr_d;

  always_comb begin
    di_c          = e1 & e2 & {WIDTH{DEDb}};
    data_c        = data_in ^ di_c;
    out_valid_d   = in_valid;
    data_out_d    = data_out_q;
    di_d          = di_q;
    corrected_d   = corrected_q;
    uncorr_d      = uncorr_q;
    // Result registers hold their last word while no new word arrives
    if (in_valid) begin
      data_out_d  = data_c;
      di_d        = di_c;
      corrected_d = |di_c;
      uncorr_d    = ~DEDb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      di_q        <= '0;
      corrected_q <= 1'b0;
      uncorr_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      di_q        <= di_d;
      corrected_q <= corrected_d;
      uncorr_q    <= uncorr_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign data_out      = data_out_q;
  assign di            = di_q;
  assign corrected     = corrected_q;
  assign uncorrectable = uncorr_q;

`ifdef SECDED_ERR_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    sat_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] ded_cnt_q,  ded_cnt_d;

  always_comb begin
    corr_cnt_d = corr_cnt_q;
    ded_cnt_d  = ded_cnt_q;
    // Clear wins over a same-cycle increment
    if (cnt_clr) begin
      corr_cnt_d = '0;
      ded_cnt_d  = '0;
    end else begin
      if (in_valid && (|di_c)) corr_cnt_d = sat_inc(corr_cnt_q);
      if (in_valid && !DEDb)   ded_cnt_d  = sat_inc(ded_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q <= '0;
      ded_cnt_q  <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      ded_cnt_q  <= ded_cnt_d;
    end
  end

  assign corr_cnt = corr_cnt_q;
  assign ded_cnt  = ded_cnt_q;
`endif

endmodule

// File: tb/tb_secded_error_corrector.sv
// Directed bench for secded_error_corrector; exercises statistics counters when SECDED_ERR_STATS_EN is defined.
module tb_secded_error_corrector;

  localparam int WIDTH = 32;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] e1;
  logic [WIDTH-1:0] e2;
  logic             DEDb;
  logic             out_valid;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] di;
  logic             corrected;
  logic             uncorrectable;
`ifdef SECDED_ERR_STATS_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] ded_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  secded_error_corrector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .data_in       (data_in),
    .e1            (e1),
    .e2            (e2),
    .DEDb          (DEDb),
    .out_valid     (out_valid),
    .data_out      (data_out),
    .di            (di),
    .corrected     (corrected),
    .uncorrectable (uncorrectable)
`ifdef SECDED_ERR_STATS_EN
    ,
    .cnt_clr       (cnt_clr),
    .corr_cnt      (corr_cnt),
    .ded_cnt       (ded_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] din;
    logic [31:0] e1v;
    logic [31:0] e2v;
    logic        dedb;
    logic [31:0] exp_dout;
    logic [31:0] exp_di;
    logic        exp_corr;
    logic        exp_unc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] a,
                       input logic [31:0] b, input logic dd);
    in_valid = v;
    data_in  = d;
    e1       = a;
    e2       = b;
    DEDb     = dd;
  endtask

  task automatic chk_outs(input string name, input logic ov, input logic [31:0] d,
                          input logic [31:0] m, input logic c, input logic u);
    chk({name, ".out_valid"},     {31'b0, out_valid},     {31'b0, ov});
    chk({name, ".data_out"},      data_out,               d);
    chk({name, ".di"},            di,                     m);
    chk({name, ".corrected"},     {31'b0, corrected},     {31'b0, c});
    chk({name, ".uncorrectable"}, {31'b0, uncorrectable}, {31'b0, u});
  endtask

  initial begin
    vecs[0]  = '{"tt0", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[1]  = '{"tt1", 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{"tt2", 32'h0, 32'h0, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[3]  = '{"tt3", 32'h0, 32'h0, 32'h1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[4]  = '{"tt4", 32'h0, 32'h1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[5]  = '{"tt5", 32'h0, 32'h1, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[6]  = '{"tt6", 32'h0, 32'h1, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[7]  = '{"tt7", 32'h0, 32'h1, 32'h1, 1'b1, 32'h1, 32'h1, 1'b1, 1'b0};
    vecs[8]  = '{"single", 32'hA5A5A5A5, 32'h00000010, 32'h00000010, 1'b1,
                 32'hA5A5A5B5, 32'h00000010, 1'b1, 1'b0};
    vecs[9]  = '{"ded", 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
                 32'h12345678, 32'h0, 1'b0, 1'b1};
    vecs[10] = '{"multi", 32'h0000FF00, 32'h0F0F0F0F, 32'h00FF00FF, 1'b1,
                 32'h000FFF0F, 32'h000F000F, 1'b1, 1'b0};
    vecs[11] = '{"e1only", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1,
                 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
`ifdef SECDED_ERR_STATS_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef SECDED_ERR_STATS_EN
    chk("reset.corr_cnt", {30'b0, corr_cnt}, 32'd0);
    chk("reset.ded_cnt",  {30'b0, ded_cnt},  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back vectors, one per cycle
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].din, vecs[i].e1v, vecs[i].e2v, vecs[i].dedb);
      @(posedge clk);
      #1;
      chk_outs(vecs[i].name, 1'b1, vecs[i].exp_dout, vecs[i].exp_di,
               vecs[i].exp_corr, vecs[i].exp_unc);
      @(negedge clk);
    end

    // Single valid pulse followed by idle with changing inputs
    drive(1'b1, 32'hA5A5A5A5, 32'h00000010, 32'h00000010, 1'b1);
    @(posedge clk);
    #1;
    chk_outs("pulse", 1'b1, 32'hA5A5A5B5, 32'h00000010, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    @(posedge clk);
    #1;
    chk_outs("hold1", 1'b0, 32'hA5A5A5B5, 32'h00000010, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_outs("hold2", 1'b0, 32'hA5A5A5B5, 32'h00000010, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with a word pending
    @(negedge clk);
    drive(1'b1, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 32'h0000FFFF, 32'h00000001, 32'h00000001, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef SECDED_ERR_STATS_EN
    chk("async_rst.corr_cnt", {30'b0, corr_cnt}, 32'd0);
    chk("async_rst.ded_cnt",  {30'b0, ded_cnt},  32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0000FFFF, 32'h00000001, 32'h00000001, 1'b1);
    @(posedge clk);
    #1;
    chk_outs("post_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

`ifdef SECDED_ERR_STATS_EN
    // Saturating counters with CNT_W=2
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0, 32'h00000100, 32'h00000100, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    chk("corr_sat", {30'b0, corr_cnt}, 32'd3);
    chk("ded_idle", {30'b0, ded_cnt},  32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      @(posedge clk);
      @(negedge clk);
      if (i == 1) chk("ded_two", {30'b0, ded_cnt}, 32'd2);
    end
    chk("ded_sat",   {30'b0, ded_cnt},  32'd3);
    chk("corr_keep", {30'b0, corr_cnt}, 32'd3);
    cnt_clr = 1'b1;
    drive(1'b1, 32'h0, 32'h00000100, 32'h00000100, 1'b1);
    @(posedge clk);
    #1;
    chk("clr.corr_cnt", {30'b0, corr_cnt}, 32'd0);
    chk("clr.ded_cnt",  {30'b0, ded_cnt},  32'd0);
    @(negedge clk);
    cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("after_clr.corr_cnt", {30'b0, corr_cnt}, 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/secded_error_corrector.md
SECDED_ERROR_CORRECTOR -- requirements
Module: secded_error_corrector

Interface
REQ-001 Parameter: WIDTH, default 32, number of corrected data bits.
REQ-002 Parameter: CNT_W, default 16, width of each statistics counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: in_valid  input  1  the current data_in/e1/e2/DEDb set is valid.
REQ-007 Port: data_in  input  WIDTH  received data word.
REQ-008 Port: e1  input  WIDTH  per-bit first syndrome check result; 1 = check failed.
REQ-009 Port: e2  input  WIDTH  per-bit second syndrome check result; 1 = check failed.
REQ-010 Port: DEDb  input  1  double-error-detect, active low; 0 = double error detected.
REQ-011 Port: out_valid  output  1  registered copy of in_valid.
REQ-012 Port: data_out  output  WIDTH  corrected data word.
REQ-013 Port: di  output  WIDTH  registered per-bit correction mask.
REQ-014 Port: corrected  output  1  a single error was corrected in this word.
REQ-015 Port: uncorrectable  output  1  a double error was detected in this word.
REQ-016 Port: cnt_clr  input  1  synchronous clear of the counters; present only with SECDED_ERR_STATS_EN.
REQ-017 Port: corr_cnt  output  CNT_W  count of corrected words; present only with SECDED_ERR_STATS_EN.
REQ-018 Port: ded_cnt  output  CNT_W  count of uncorrectable words; present only with SECDED_ERR_STATS_EN.

Function
REQ-019 Per bit i: raw correction di_c[i] = e1[i] AND e2[i] AND DEDb.
- Truth table per bit for {e1,e2,DEDb} = 0..7: di_c = 0,0,0,0,0,0,0,1.
- Only 111 gives 1.
REQ-020 data_c = data_in XOR di_c.
REQ-021 Latency: one clock from in_valid to out_valid. On each rising edge with in_valid=1, the block SHALL register:
- data_out <= data_c
- di <= di_c
- corrected <= |di_c
- uncorrectable <= ~DEDb
REQ-022 With in_valid=0, the block SHALL hold data_out, di, corrected and uncorrectable, and SHALL clear out_valid to 0 on the next edge.
REQ-023 With DEDb=0, di SHALL be all zeros, data_out SHALL equal data_in, and corrected SHALL be 0, for any e1/e2.
- The uncorrected word is passed through.
REQ-024 Multiple bits with e1&e2 set while DEDb=1 SHALL all be flipped. No single-bit limit is enforced.
REQ-025 There is no backpressure; a new word is accepted on every cycle with in_valid=1.

Reset
REQ-026 With rst_n low, the block SHALL asynchronously drive out_valid, data_out, di, corrected, uncorrectable, corr_cnt and ded_cnt to 0.
REQ-027 Reset deassertion SHALL take effect on the first rising clk edge after rst_n goes high.
REQ-028 A word in flight when reset asserts SHALL be discarded.

Configuration
REQ-029 The macro SECDED_ERR_STATS_EN SHALL control the statistics logic.
REQ-030 With SECDED_ERR_STATS_EN defined, the block SHALL behave as follows on each edge:
- corr_cnt increments when in_valid and |di_c are both 1.
- ded_cnt increments when in_valid is 1 and DEDb is 0.
- Both counters saturate at all-ones and do not wrap.
- cnt_clr=1 zeros both counters; cnt_clr has priority over an increment in the same cycle.
REQ-031 Without SECDED_ERR_STATS_EN, the ports cnt_clr, corr_cnt and ded_cnt and their logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-032 Truth-table sweep, single bit 0, for {e1[0],e2[0],DEDb} = 0..7 with data_in=0 and in_valid=1.
- Required: di[0] = 1 only for code 7, one cycle later; otherwise 0.
REQ-033 Stimulus: data_in=0xA5A5A5A5, e1=e2=0x00000010, DEDb=1.
- Required: data_out=0xA5A5A5B5, di=0x00000010, corrected=1, uncorrectable=0.
REQ-034 Stimulus: data_in=0x12345678, e1=e2=0xFFFFFFFF, DEDb=0.
- Required: data_out=0x12345678, di=0, corrected=0, uncorrectable=1.
REQ-035 Stimulus: apply rst_n=0 mid-stream while a valid word is pending.
- Required: all outputs are 0 immediately, without waiting for a clk edge.
REQ-036 Stimulus (SECDED_ERR_STATS_EN, CNT_W=2): drive 5 corrected words, then raise cnt_clr together with a corrected word.
- Required: corr_cnt = 3 (saturated), then 0.
REQ-037 Stimulus: in_valid=1 for one cycle, then 0.
- Required: out_valid pulses for one cycle; data_out holds its value afterwards.
